// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - word handshake between a producer and uart_tx
interface uart_tx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - async serial transmitter with one-word holding register
module uart_tx #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic     clk_in,
   input  logic     reset,
   input  logic     baud_tick,
   uart_tx_if.slave tx_if,
   output logic     tx,
   output logic     tx_busy
);
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   logic [2:0]           state_q, state_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 hold_full_q, hold_full_d;
   logic                 parity_q, parity_d;
   logic                 tx_q, tx_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic                 accept;
   logic                 last_stop;
   logic                 launch;

   assign accept    = tx_if.tx_valid && !hold_full_q;
   assign last_stop = (state_q == ST_STOP) && (bit_cnt_q == LAST_STOP);
   // Launching from the last stop bit is what makes back-to-back frames gapless.
   assign launch    = baud_tick && hold_full_q && ((state_q == ST_IDLE) || last_stop);

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      tx_d        = tx_q;
      bit_cnt_d   = bit_cnt_q;

      if (accept) begin
         hold_d      = tx_if.tx_data;
         hold_full_d = 1'b1;
      end

      if (launch) begin
         shift_d     = hold_q;
         parity_d    = (PARITY == 1) ? ~^hold_q : ^hold_q;
         hold_full_d = 1'b0;
         state_d     = ST_START;
         tx_d        = 1'b0;
         bit_cnt_d   = 4'd0;
      end else if (baud_tick) begin
         case (state_q)
            ST_IDLE: begin
               tx_d = 1'b1;
            end
            ST_START: begin
               state_d   = ST_DATA;
               tx_d      = shift_q[0];
               bit_cnt_d = 4'd0;
            end
            ST_DATA: begin
               if (bit_cnt_q == LAST_DATA) begin
                  bit_cnt_d = 4'd0;
                  if (PARITY != 0) begin
                     state_d = ST_PARITY;
                     tx_d    = parity_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            ST_PARITY: begin
               state_d   = ST_STOP;
               tx_d      = 1'b1;
               bit_cnt_d = 4'd0;
            end
            ST_STOP: begin
               if (last_stop) begin
                  state_d   = ST_IDLE;
                  tx_d      = 1'b1;
                  bit_cnt_d = 4'd0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               tx_d      = 1'b1;
               bit_cnt_d = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         tx_q        <= 1'b1;
         bit_cnt_q   <= 4'd0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         tx_q        <= tx_d;
         bit_cnt_q   <= bit_cnt_d;
      end
   end

   assign tx             = tx_q;
   assign tx_busy        = (state_q != ST_IDLE);
   assign tx_if.tx_ready = !hold_full_q;
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the ADC link: accepts parallel words over a valid/ready handshake and drives an asynchronous serial frame (start, data LSB-first, optional parity, stop) on `tx`. Bit timing comes from a one-cycle `baud_tick` strobe produced by the upstream baud stage in the `clk_in` domain. A one-entry holding register lets the producer queue the next word while the current frame is shifting, so consecutive frames go out with no idle gap.

## Interface
- `DATA_BITS`, default 8: data bits per frame, 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.

- `clk_in`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high; priority over every other input.
- `baud_tick`  in  1  one-`clk_in`-cycle strobe per bit period. Each high cycle counts as one tick; no edge detection.
- `tx_data`  in  DATA_BITS  word to send; sampled on acceptance.
- `tx_valid`  in  1  producer has a word on `tx_data`.
- `tx_ready`  out  1  holding register empty; transfer occurs on an edge where `tx_valid && tx_ready`.
- `tx`  out  1  serial line, registered, idle high.
- `tx_busy`  out  1  high while a frame is on the line (state != IDLE).

## Operation
- States: IDLE, START, DATA, PARITY (only when PARITY != 0), STOP.
- Holding register: loaded on an accept edge. `hold_full` is set; `tx_ready = !hold_full`, registered.
- Launch condition: `baud_tick` is high and `hold_full` is set, and either state is IDLE or state is STOP on its last stop bit. On that edge:
  - Hold is copied into the shifter.
  - The parity bit is computed.
  - `hold_full` clears.
  - The state goes to START, and `tx` goes to 0.
- Tick-driven transitions:
  - START → DATA: `tx` = shifter bit 0.
  - DATA: shift right on each tick. After DATA_BITS bits, go to PARITY, or to STOP if PARITY = 0.
  - PARITY → STOP: `tx` = 1.
  - STOP: count STOP_BITS ticks. On the final tick, launch if `hold_full`; otherwise go to IDLE with `tx` = 1.
- Parity:
  - Even: XOR-reduce of the data bits.
  - Odd: inverted XOR-reduce of the data bits.
- Without `baud_tick`, the state, `tx` and the bit counter hold.
- Frame length is 1 + DATA_BITS + (PARITY != 0) + STOP_BITS tick periods.
- Accepts are independent of the state machine. A new word may be accepted during any frame phase once hold is empty.

## Timing
- Reset (edge with `reset` = 1):
  - State → IDLE, `tx` = 1, `tx_busy` = 0, `hold_full` = 0, `tx_ready` = 1, bit counter = 0.
  - A reset mid-frame aborts the frame. The line returns high on that edge and the held word is discarded.
  - `baud_tick` and `tx_valid` are ignored in any reset cycle.
- Accept at edge E0: `tx_ready` is low from E0 until the launch edge, then high the cycle after launch.
- Launch latency:
  - The start bit begins at the first `baud_tick` edge strictly after E0.
  - A tick coinciding with E0 does not launch, because hold is not yet full at that edge.
- Every bit lasts exactly one tick-to-tick interval. `tx` changes only on tick edges, or on a reset edge.
- `tx_busy` rises on the launch edge. It falls on the final stop-tick edge only if no launch occurs there.
- Back-to-back frames: the next start bit immediately follows the last stop bit, with zero idle cycles.
- `tx_valid` dropped without an accept has no effect. `tx_data` is don't-care except on accept edges.

## Test plan
- Reset mid-frame: 0x55 in DATA state, `reset` high 2 cycles → after the first reset edge `tx` = 1, `tx_busy` = 0, `tx_ready` = 1. The next frame starts cleanly after a new accept.
- Basic frame: DATA_BITS = 8, PARITY = 0, STOP_BITS = 1, tick every 16 cycles, send 0x55 → `tx` carries the 10 bits 0,1,0,1,0,1,0,1,0,1, each exactly 16 cycles, starting at the first tick after accept. `tx_busy` is high for 160 cycles.
- Parity: send 0x07 with PARITY = 2 → parity bit 1. With PARITY = 1 → parity bit 0. Frame length is 11 ticks.
- Back-to-back: hold `tx_valid` with 0xA5 then 0x3C →
  - `tx_ready` drops after each accept and rises the cycle after each launch.
  - The second start bit begins on the tick ending the first stop bit; no idle gap.
  - Both words are received intact.
- Tick/accept collision: in IDLE, `baud_tick` and the accept on the same edge → `tx` stays 1 until the next tick, then the start bit begins.
- Two stop bits: STOP_BITS = 2, send 0x00 → the line is low for 9 tick periods (start plus 8 data bits), then high for 2 tick periods, then IDLE.
